regfile_param: RTL and testbench

//   Parametrised register file for the tinymips datapath: two async read ports and one sync write port.

---
 rtl/regfile_param.sv | 128 ++++++++++++
 tb/tb_regfile_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: two async core read ports, one sync core write port,
// a monitor read port, and a handshaked monitor write port. After reset, the FSM
// clears every entry one per cycle before entering RUN.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_ra,
  output logic [DATA_W-1:0] dbg_rd,
  input  logic              dbg_wreq,
  input  logic [ADDR_W-1:0] dbg_wa,
  input  logic [DATA_W-1:0] dbg_wd,
  output logic              dbg_wack,
  output logic              init_done
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  // One extra bit so NREGS == 2**ADDR_W is representable and the index cannot wrap.
  localparam logic [ADDR_W:0] NregsW  = (ADDR_W + 1)'(NREGS);
  localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(NREGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              dbg_wack_q, dbg_wack_d;
  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  logic run;
  logic core_wr;
  logic dbg_commit;
  logic dbg_wr;

  // An address is writable/readable if in range and not the hardwired zero entry.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NregsW) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Control state and the registered debug acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StClear;
      idx_q      <= '0;
      dbg_wack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dbg_wack_q <= dbg_wack_d;
    end
  end

  // Storage is cleared by the FSM, so it needs no reset of its own.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Next state: walk the clear index, then sit in RUN until reset.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StClear: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) state_d = StRun;
      end
      StRun:   ;
      default: state_d = StClear;
    endcase
  end

  // FSM outputs and write arbitration; the core always wins, and a request still
  // high during its own ack cycle must not commit a second time.
  always_comb begin
    run        = (state_q == StRun);
    init_done  = run;
    core_wr    = run && we3 && addr_ok(wa3);
    dbg_commit = run && dbg_wreq && !we3 && !dbg_wack_q;
    dbg_wr     = dbg_commit && addr_ok(dbg_wa);
    dbg_wack_d = dbg_commit;
    dbg_wack   = dbg_wack_q;
  end

  // Next contents: clear one entry per cycle, or apply at most one write.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NREGS; i++) begin
      if (!run) begin
        if (idx_q == (ADDR_W + 1)'(i)) mem_d[i] = '0;
      end else if (core_wr && (wa3 == ADDR_W'(i))) begin
        mem_d[i] = wd3;
      end else if (dbg_wr && (dbg_wa == ADDR_W'(i))) begin
        mem_d[i] = dbg_wd;
      end
    end
  end

  // Read muxes; reads are forced to 0 while clearing, the monitor port is never bypassed.
  always_comb begin
    rd1    = '0;
    rd2    = '0;
    dbg_rd = '0;
    if (run) begin
      for (int i = 0; i < NREGS; i++) begin
        if (ra1 == ADDR_W'(i))    rd1    = mem_q[i];
        if (ra2 == ADDR_W'(i))    rd2    = mem_q[i];
        if (dbg_ra == ADDR_W'(i)) dbg_rd = mem_q[i];
      end
      if (!addr_ok(ra1))    rd1    = '0;
      if (!addr_ok(ra2))    rd2    = '0;
      if (!addr_ok(dbg_ra)) dbg_rd = '0;
      if ((BYPASS != 0) && core_wr && (wa3 == ra1)) rd1 = wd3;
      if ((BYPASS != 0) && core_wr && (wa3 == ra2)) rd2 = wd3;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: one default instance (32 entries, bypass)
// and one with 24 entries and no bypass, both driven from the same stimulus.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we3 = 1'b0;
  logic [4:0]  wa3 = '0, ra1 = '0, ra2 = '0, dbg_ra = '0, dbg_wa = '0;
  logic [31:0] wd3 = '0, dbg_wd = '0;
  logic        dbg_wreq = 1'b0;

  logic [31:0] rd1_a, rd2_a, dbg_rd_a, rd1_b, rd2_b, dbg_rd_b;
  logic        dbg_wack_a, init_done_a, dbg_wack_b, init_done_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;
  sb_item_t sb_q[$];

  regfile_param u_dut_a (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd_a), .dbg_wreq(dbg_wreq), .dbg_wa(dbg_wa),
    .dbg_wd(dbg_wd), .dbg_wack(dbg_wack_a), .init_done(init_done_a)
  );

  regfile_param #(.NREGS(24), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd_b), .dbg_wreq(dbg_wreq), .dbg_wa(dbg_wa),
    .dbg_wd(dbg_wd), .dbg_wack(dbg_wack_b), .init_done(init_done_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic pop_check(input logic [31:0] got);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: got 0x%08h required an expectation", got);
    end else begin
      it = sb_q.pop_front();
      check_val(it.tag, got, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the clear after reset release, returning cycles until each init_done rose.
  task automatic run_clear(output int na, output int nb, output bit wack_seen,
                           output bit rd_bad);
    na = 0; nb = 0; wack_seen = 0; rd_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (dbg_wack_a || dbg_wack_b) wack_seen = 1;
      if (!init_done_a && (rd1_a != 0 || rd2_a != 0 || dbg_rd_a != 0)) rd_bad = 1;
      if (init_done_b && nb == 0) begin
        nb = c;
        we3 = 1'b0;
        dbg_wreq = 1'b0;
      end
      if (init_done_a) begin
        na = c;
        break;
      end
    end
  endtask

  initial begin
    int  na, nb;
    bit  wack_seen, rd_bad;

    // Reset state.
    tick();
    push_exp("rst_init_done", 0); pop_check(32'(init_done_a));
    push_exp("rst_wack", 0);      pop_check(32'(dbg_wack_a));
    push_exp("rst_rd1", 0);       pop_check(rd1_a);

    // Clear with writes and a debug request attempted throughout.
    we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hAA; ra1 = 5'd5; ra2 = 5'd5; dbg_ra = 5'd5;
    dbg_wreq = 1'b1; dbg_wa = 5'd6; dbg_wd = 32'hBB;
    reset = 1'b0;
    #1;
    push_exp("clr_init_done0", 0); pop_check(32'(init_done_a));
    run_clear(na, nb, wack_seen, rd_bad);
    we3 = 1'b0; dbg_wreq = 1'b0;
    check_val("clr_len_a", 32'(na), 32);
    check_val("clr_len_b", 32'(nb), 24);
    check_val("clr_no_wack", 32'(wack_seen), 0);
    check_val("clr_rd_forced0", 32'(rd_bad), 0);

    for (int i = 0; i < 32; i++) begin
      dbg_ra = 5'(i);
      push_exp($sformatf("clr_a_e%0d", i), 0);
      if (i < 24) push_exp($sformatf("clr_b_e%0d", i), 0);
      #1;
      pop_check(dbg_rd_a);
      if (i < 24) pop_check(dbg_rd_b);
    end

    // Plain write then read; writes to entry 0 are dropped.
    we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hDEADBEEF;
    tick();
    we3 = 1'b0; ra1 = 5'd7;
    push_exp("wr7_rd1_a", 32'hDEADBEEF); push_exp("wr7_rd1_b", 32'hDEADBEEF);
    #1; pop_check(rd1_a); pop_check(rd1_b);
    we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h1; ra2 = 5'd0;
    tick();
    we3 = 1'b0;
    push_exp("zero_rd2", 0); push_exp("zero_dbg", 0);
    dbg_ra = 5'd0;
    #1; pop_check(rd2_a); pop_check(dbg_rd_a);

    // Same-cycle bypass on A, none on B.
    we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h55; ra1 = 5'd3; dbg_ra = 5'd3;
    push_exp("byp_rd1_a", 32'h55); push_exp("nobyp_rd1_b", 0); push_exp("byp_dbg_a", 0);
    #1; pop_check(rd1_a); pop_check(rd1_b); pop_check(dbg_rd_a);
    tick();
    we3 = 1'b0;
    push_exp("post_rd1_b", 32'h55);
    #1; pop_check(rd1_b);

    // Debug write held off by core writes.
    dbg_wreq = 1'b1; dbg_wa = 5'd9; dbg_wd = 32'h1234;
    we3 = 1'b1; wa3 = 5'd10; wd3 = 32'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      push_exp($sformatf("hold_wack_%0d", i), 0);
      pop_check(32'(dbg_wack_a));
    end
    we3 = 1'b0;
    tick();
    push_exp("ack_a", 1); push_exp("ack_b", 1);
    pop_check(32'(dbg_wack_a)); pop_check(32'(dbg_wack_b));
    tick();
    push_exp("ack_once", 0); pop_check(32'(dbg_wack_a));
    dbg_wreq = 1'b0;
    tick();
    push_exp("ack_stay0", 0); pop_check(32'(dbg_wack_a));
    dbg_ra = 5'd9; ra1 = 5'd10;
    push_exp("dbg9_a", 32'h1234); push_exp("dbg9_b", 32'h1234); push_exp("core10", 32'h11);
    #1; pop_check(dbg_rd_a); pop_check(dbg_rd_b); pop_check(rd1_a);

    // Out-of-range writes on the 24-entry instance are acked but discarded.
    dbg_wreq = 1'b1; dbg_wa = 5'd30; dbg_wd = 32'hCAFE;
    tick();
    push_exp("oor_ack_b", 1); pop_check(32'(dbg_wack_b));
    dbg_wreq = 1'b0;
    tick();
    ra1 = 5'd30;
    push_exp("oor_rd1_a", 32'hCAFE); push_exp("oor_rd1_b", 0);
    #1; pop_check(rd1_a); pop_check(rd1_b);
    we3 = 1'b1; wa3 = 5'd23; wd3 = 32'h2323;
    tick();
    wa3 = 5'd24; wd3 = 32'h2424;
    tick();
    we3 = 1'b0; ra1 = 5'd23; ra2 = 5'd24;
    push_exp("last_b", 32'h2323); push_exp("e24_b", 0); push_exp("e24_a", 32'h2424);
    #1; pop_check(rd1_b); pop_check(rd2_b); pop_check(rd2_a);

    // Reset mid-run with entry 4 populated and a debug write pending.
    we3 = 1'b1; wa3 = 5'd4; wd3 = 32'h77;
    tick();
    we3 = 1'b0; ra1 = 5'd4;
    push_exp("pre_rst_rd1", 32'h77);
    #1; pop_check(rd1_a);
    we3 = 1'b1; wa3 = 5'd10; wd3 = 32'h5;
    dbg_wreq = 1'b1; dbg_wa = 5'd4; dbg_wd = 32'h99; dbg_ra = 5'd4;
    tick();
    push_exp("pend_wack", 0); pop_check(32'(dbg_wack_a));
    #2 reset = 1'b1;
    #1;
    push_exp("mid_rst_rd1_a", 0); push_exp("mid_rst_rd1_b", 0);
    push_exp("mid_rst_dbg", 0);   push_exp("mid_rst_done", 0);
    pop_check(rd1_a); pop_check(rd1_b); pop_check(dbg_rd_a); pop_check(32'(init_done_a));
    tick();
    reset = 1'b0; we3 = 1'b0; dbg_wreq = 1'b0;
    run_clear(na, nb, wack_seen, rd_bad);
    check_val("re_clr_len_a", 32'(na), 32);
    check_val("re_clr_no_wack", 32'(wack_seen), 0);
    push_exp("re_e4_a", 0); push_exp("re_e4_b", 0); push_exp("re_rd1_a", 0);
    #1; pop_check(dbg_rd_a); pop_check(dbg_rd_b); pop_check(rd1_a);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
